// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and the immediate-format encoding used by the
// immediate generator and its consumers in decode.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_FMT_NONE  = 3'd0,
        IMM_FMT_I     = 3'd1,
        IMM_FMT_SHAMT = 3'd2,
        IMM_FMT_S     = 3'd3,
        IMM_FMT_B     = 3'd4,
        IMM_FMT_U     = 3'd5,
        IMM_FMT_J     = 3'd6,
        IMM_FMT_CSR   = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: classifies the opcode and produces the
// XLEN-wide immediate, its format code and an unrecognised-opcode flag.
module imm_extract
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic               is_shift;
    logic signed [31:0] simm;
    logic [5:0]         uimm;

    assign opc      = inst_i[6:0];
    assign f3       = inst_i[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Opcode decode; signed formats build a 32-bit value, unsigned ones a 6-bit field
    always_comb begin
        simm      = '0;
        uimm      = '0;
        fmt_o     = IMM_FMT_NONE;
        illegal_o = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                fmt_o = IMM_FMT_I;
                simm  = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    fmt_o = IMM_FMT_SHAMT;
                    uimm  = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
                end else begin
                    fmt_o = IMM_FMT_I;
                    simm  = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_OP_IMM_32: begin
                // Word ops only exist on RV64; shift amounts stay 5 bits
                if (XLEN == 64) begin
                    if (is_shift) begin
                        fmt_o = IMM_FMT_SHAMT;
                        uimm  = {1'b0, inst_i[24:20]};
                    end else begin
                        fmt_o = IMM_FMT_I;
                        simm  = {{20{inst_i[31]}}, inst_i[31:20]};
                    end
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt_o = IMM_FMT_S;
                simm  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = IMM_FMT_B;
                simm  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = IMM_FMT_U;
                simm  = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = IMM_FMT_J;
                simm  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                // CSR*I forms carry zimm in the rs1 field; everything else has no immediate
                if (CSR_EN && (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111)) begin
                    fmt_o = IMM_FMT_CSR;
                    uimm  = {1'b0, inst_i[19:15]};
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

    // Widen to XLEN: sign-extend signed formats, zero-extend shamt/zimm
    always_comb begin
        if (fmt_o == IMM_FMT_SHAMT || fmt_o == IMM_FMT_CSR) begin
            imm_o = XLEN'(uimm);
        end else begin
            imm_o = XLEN'(simm);
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one registered output slot plus a one-entry
// skid buffer so the input never depends combinationally on OUT_READY.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 32,
    parameter bit CSR_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INST,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMMEDIATE,
    output logic [2:0]       FMT,
    output logic             ILLEGAL,
    output logic [TAG_W-1:0] OUT_TAG
);

    logic [XLEN-1:0]  new_imm;
    imm_fmt_e         new_fmt;
    logic             new_ill;

    logic             or_vld_q, or_vld_d, sk_vld_q, sk_vld_d;
    logic [XLEN-1:0]  or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
    imm_fmt_e         or_fmt_q, or_fmt_d, sk_fmt_q, sk_fmt_d;
    logic             or_ill_q, or_ill_d, sk_ill_q, sk_ill_d;
    logic [TAG_W-1:0] or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
    logic             accept, out_fire;

    imm_extract #(.XLEN(XLEN), .CSR_EN(CSR_EN)) u_extract (
        .inst_i    (INST),
        .imm_o     (new_imm),
        .fmt_o     (new_fmt),
        .illegal_o (new_ill)
    );

    assign IN_READY  = !sk_vld_q && !RESET;
    assign accept    = IN_VALID && IN_READY && !FLUSH;
    assign out_fire  = or_vld_q && OUT_READY;

    assign OUT_VALID = or_vld_q;
    assign IMMEDIATE = or_imm_q;
    assign FMT       = or_fmt_q;
    assign ILLEGAL   = or_ill_q;
    assign OUT_TAG   = or_tag_q;

    // Steer new results into OR or SK; SK drains into OR first to keep FIFO order
    always_comb begin
        or_vld_d = or_vld_q;
        or_imm_d = or_imm_q;
        or_fmt_d = or_fmt_q;
        or_ill_d = or_ill_q;
        or_tag_d = or_tag_q;
        sk_vld_d = sk_vld_q;
        sk_imm_d = sk_imm_q;
        sk_fmt_d = sk_fmt_q;
        sk_ill_d = sk_ill_q;
        sk_tag_d = sk_tag_q;
        if (FLUSH) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || out_fire) begin
            if (sk_vld_q) begin
                or_vld_d = 1'b1;
                or_imm_d = sk_imm_q;
                or_fmt_d = sk_fmt_q;
                or_ill_d = sk_ill_q;
                or_tag_d = sk_tag_q;
                sk_vld_d = 1'b0;
            end else if (accept) begin
                or_vld_d = 1'b1;
                or_imm_d = new_imm;
                or_fmt_d = new_fmt;
                or_ill_d = new_ill;
                or_tag_d = IN_TAG;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (accept) begin
            sk_vld_d = 1'b1;
            sk_imm_d = new_imm;
            sk_fmt_d = new_fmt;
            sk_ill_d = new_ill;
            sk_tag_d = IN_TAG;
        end
    end

    // State update; reset clears data too so the outputs read as zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            or_vld_q <= 1'b0;
            or_imm_q <= '0;
            or_fmt_q <= IMM_FMT_NONE;
            or_ill_q <= 1'b0;
            or_tag_q <= '0;
            sk_vld_q <= 1'b0;
            sk_imm_q <= '0;
            sk_fmt_q <= IMM_FMT_NONE;
            sk_ill_q <= 1'b0;
            sk_tag_q <= '0;
        end else begin
            or_vld_q <= or_vld_d;
            or_imm_q <= or_imm_d;
            or_fmt_q <= or_fmt_d;
            or_ill_q <= or_ill_d;
            or_tag_q <= or_tag_d;
            sk_vld_q <= sk_vld_d;
            sk_imm_q <= sk_imm_d;
            sk_fmt_q <= sk_fmt_d;
            sk_ill_q <= sk_ill_d;
            sk_tag_q <= sk_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an RV32 and an RV64 instance share one input stream;
// expected results are queued per instance and popped by a monitor.
module tb_imm_gen_pipe;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, IN_VALID, OUT_READY;
    logic [31:0] INST, IN_TAG;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t m32, m64;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CSR_EN(1'b1)) dut32 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy32),
        .INST(INST), .IN_TAG(IN_TAG), .OUT_VALID(vld32), .OUT_READY(OUT_READY),
        .IMMEDIATE(imm32), .FMT(fmt32), .ILLEGAL(ill32), .OUT_TAG(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CSR_EN(1'b1)) dut64 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy64),
        .INST(INST), .IN_TAG(IN_TAG), .OUT_VALID(vld64), .OUT_READY(OUT_READY),
        .IMMEDIATE(imm64), .FMT(fmt64), .ILLEGAL(ill64), .OUT_TAG(tag64)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: every output transfer pops and compares the oldest expectation
    always @(negedge CLK) begin
        if (vld32 && OUT_READY) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out32_unexpected tag actual=%h expected=none", tag32);
            end else begin
                m32 = q32.pop_front();
                chk("imm32", {32'b0, imm32}, {32'b0, m32.imm[31:0]});
                chk("fmt32", {61'b0, fmt32}, {61'b0, m32.fmt});
                chk("ill32", {63'b0, ill32}, {63'b0, m32.ill});
                chk("tag32", {32'b0, tag32}, {32'b0, m32.tag});
            end
        end
        if (vld64 && OUT_READY) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out64_unexpected tag actual=%h expected=none", tag64);
            end else begin
                m64 = q64.pop_front();
                chk("imm64", imm64, m64.imm);
                chk("fmt64", {61'b0, fmt64}, {61'b0, m64.fmt});
                chk("ill64", {63'b0, ill64}, {63'b0, m64.ill});
                chk("tag64", {32'b0, tag64}, {32'b0, m64.tag});
            end
        end
    end

    // Offer one instruction; queue expectations once the handshake will complete
    task automatic send(input logic [31:0] inst, input logic [31:0] tag,
                        input logic [31:0] i32, input logic [2:0] f32, input logic l32,
                        input logic [63:0] i64, input logic [2:0] f64, input logic l64);
        int n;
        exp_t e;
        IN_VALID = 1'b1;
        INST     = inst;
        IN_TAG   = tag;
        n = 0;
        @(negedge CLK);
        while (!rdy32 && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!rdy32) begin
            checks++;
            errors++;
            $display("FAIL send_timeout tag actual=%h expected=accepted", tag);
        end else begin
            e.imm = {32'b0, i32}; e.fmt = f32; e.ill = l32; e.tag = tag;
            q32.push_back(e);
            e.imm = i64; e.fmt = f64; e.ill = l64; e.tag = tag;
            q64.push_back(e);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk("drain_empty", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_vld"}, {62'b0, vld32, vld64}, 64'd0);
        chk({name, "_imm32"}, {32'b0, imm32}, 64'd0);
        chk({name, "_imm64"}, imm64, 64'd0);
        chk({name, "_fmt"}, {58'b0, fmt32, fmt64}, 64'd0);
        chk({name, "_ill"}, {62'b0, ill32, ill64}, 64'd0);
        chk({name, "_tag"}, {tag32, tag64}, 64'd0);
        chk({name, "_rdy"}, {62'b0, rdy32, rdy64}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        INST = '0; IN_TAG = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_state("reset");
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("ready_after_reset", {62'b0, rdy32, rdy64}, 64'd3);

        // Single-cycle latency into an empty output register
        send(32'hFFF00093, 32'hA0, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        chk("latency_vld", {62'b0, vld32, vld64}, 64'd3);
        chk("latency_tag", {32'b0, tag32}, 64'hA0);

        // Back-to-back directed vectors at full throughput
        send(32'h41F0D093, 32'hA1, 32'h0000001F, 3'd2, 1'b0, 64'h1F, 3'd2, 1'b0);
        send(32'h43F0D093, 32'hA2, 32'h0000001F, 3'd2, 1'b0, 64'h3F, 3'd2, 1'b0);
        send(32'hFE000EE3, 32'hA3, 32'hFFFFFFFC, 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        send(32'h0040006F, 32'hA4, 32'h00000004, 3'd6, 1'b0, 64'h4, 3'd6, 1'b0);
        send(32'h800000B7, 32'hA5, 32'h80000000, 3'd5, 1'b0, 64'hFFFFFFFF80000000, 3'd5, 1'b0);
        send(32'hFE112C23, 32'hA6, 32'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
        send(32'h300FD073, 32'hA7, 32'h0000001F, 3'd7, 1'b0, 64'h1F, 3'd7, 1'b0);
        send(32'h00000073, 32'hA8, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
        send(32'hFFF0809B, 32'hA9, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send(32'h7FF00083, 32'hAA, 32'h000007FF, 3'd1, 1'b0, 64'h7FF, 3'd1, 1'b0);
        send(32'h12345097, 32'hAB, 32'h12345000, 3'd5, 1'b0, 64'h12345000, 3'd5, 1'b0);
        send(32'h0000007F, 32'hAC, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
        drain();

        // Backpressure: tags 1 and 2 fill OR and SK, tag 3 waits
        OUT_READY = 1'b0;
        send(32'hFFF00093, 32'd1, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send(32'h0040006F, 32'd2, 32'h00000004, 3'd6, 1'b0, 64'h4, 3'd6, 1'b0);
        chk("bp_ready_low", {62'b0, rdy32, rdy64}, 64'd0);
        fork
            send(32'hFE000EE3, 32'd3, 32'hFFFFFFFC, 3'd4, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
            begin
                repeat (3) @(posedge CLK);
                #1;
                chk("bp_ready_held", {62'b0, rdy32, rdy64}, 64'd0);
                chk("bp_stable_tag", {32'b0, tag32}, 64'd1);
                chk("bp_stable_imm", {32'b0, imm32}, 64'hFFFFFFFF);
                OUT_READY = 1'b1;
            end
        join
        drain();

        // Flush with both slots full and a same-cycle offer
        OUT_READY = 1'b0;
        send(32'h0040006F, 32'h10, 32'h00000004, 3'd6, 1'b0, 64'h4, 3'd6, 1'b0);
        send(32'h800000B7, 32'h11, 32'h80000000, 3'd5, 1'b0, 64'hFFFFFFFF80000000, 3'd5, 1'b0);
        IN_VALID = 1'b1; INST = 32'h12345097; IN_TAG = 32'hDEAD; FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        q32.delete();
        q64.delete();
        chk("flush_vld", {62'b0, vld32, vld64}, 64'd0);
        chk("flush_rdy", {62'b0, rdy32, rdy64}, 64'd3);
        OUT_READY = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("flush_no_output", {62'b0, vld32, vld64}, 64'd0);
        send(32'h0000007F, 32'h12, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
        drain();

        // Reset mid-stream discards everything
        OUT_READY = 1'b0;
        send(32'hFFF00093, 32'h20, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send(32'h41F0D093, 32'h21, 32'h0000001F, 3'd2, 1'b0, 64'h1F, 3'd2, 1'b0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        q32.delete();
        q64.delete();
        chk_reset_state("midreset");
        RESET = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        chk("midreset_rdy", {62'b0, rdy32, rdy64}, 64'd3);
        chk("midreset_vld", {62'b0, vld32, vld64}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
